// File: rtl/conv_stream_if.sv
// Stream-side and core-side signal bundle for the CONV_GAUSS sequencer.
// The slave modport is the controller's view and the master modport is the surrounding fabric's view.
interface conv_stream_if #(
    parameter int DATA_WIDTH = 64
);
    logic                  s_tvalid;
    logic                  s_tready;
    logic [DATA_WIDTH-1:0] s_tdata;
    logic                  s_tlast;
    logic                  conv_stall;
    logic [DATA_WIDTH-1:0] conv_in;
    logic [DATA_WIDTH-1:0] conv_out;
    logic                  m_tvalid;
    logic                  m_tready;
    logic [DATA_WIDTH-1:0] m_tdata;
    logic                  m_tlast;

    modport slave (
        input  s_tvalid, s_tdata, s_tlast, conv_out, m_tready,
        output s_tready, conv_stall, conv_in, m_tvalid, m_tdata, m_tlast
    );

    modport master (
        output s_tvalid, s_tdata, s_tlast, conv_out, m_tready,
        input  s_tready, conv_stall, conv_in, m_tvalid, m_tdata, m_tlast
    );
endinterface

// File: rtl/conv_stream_ctrl.sv
// AXI-Stream sequencer for the CONV_GAUSS core.
// It masks the pipeline fill, zero-pads the drain, and frames the output stream.
module conv_stream_ctrl #(
    parameter int PIXELS_PER_BEAT = 8,
    parameter int IMAGE_DIM       = 64,
    parameter int PIPE_LAT        = 18,
    parameter int DATA_WIDTH      = 8 * PIXELS_PER_BEAT,
    parameter int BEATS_PER_FRAME = IMAGE_DIM * IMAGE_DIM / PIXELS_PER_BEAT
) (
    input  logic          clk,
    input  logic          aresetn,
    conv_stream_if.slave  io,
    output logic          busy,
    output logic          frame_err
);
    localparam int CW = $clog2(BEATS_PER_FRAME);
    localparam int AW = $clog2(PIPE_LAT + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(BEATS_PER_FRAME - 1);
    localparam logic [CW:0]   BPF_W    = (CW + 1)'(BEATS_PER_FRAME);
    localparam logic [AW-1:0] LAT_W    = AW'(PIPE_LAT);

    typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] in_cnt_q, in_cnt_d;
    logic [CW-1:0] out_cnt_q, out_cnt_d;
    logic [AW-1:0] adv_cnt_q, adv_cnt_d;
    logic          m_tvalid_q, m_tvalid_d;
    logic          frame_err_q, frame_err_d;

    logic          out_ok;
    logic          in_phase;
    logic          s_rdy;
    logic          accept;
    logic          advance;
    logic          hshk;
    logic          last_in;
    logic          last_out;
    logic          end_in;
    logic [CW:0]   emitted;
    logic          flush_more;

    assign out_ok   = ~m_tvalid_q | io.m_tready;
    assign in_phase = (state_q != FLUSH);
    assign s_rdy    = aresetn & in_phase & out_ok;
    assign accept   = io.s_tvalid & s_rdy;
    assign hshk     = m_tvalid_q & io.m_tready;
    assign last_in  = (in_cnt_q == LAST_IDX);
    assign last_out = (out_cnt_q == LAST_IDX);
    assign end_in   = accept & (io.s_tlast | last_in);

    // Once the core is primed, each drain advance yields one more beat; stop at a full frame.
    assign emitted    = {1'b0, out_cnt_q} + (CW + 1)'(m_tvalid_q);
    assign flush_more = (emitted < BPF_W);
    assign advance    = in_phase ? accept : (out_ok & flush_more);

    assign io.s_tready   = s_rdy;
    assign io.conv_stall = ~advance;
    assign io.conv_in    = in_phase ? io.s_tdata : '0;
    assign io.m_tvalid   = m_tvalid_q;
    assign io.m_tdata    = io.conv_out;
    assign io.m_tlast    = m_tvalid_q & last_out;
    assign busy          = (state_q != IDLE);
    assign frame_err     = frame_err_q;

    always_comb begin
        state_d     = state_q;
        in_cnt_d    = in_cnt_q;
        out_cnt_d   = out_cnt_q;
        adv_cnt_d   = adv_cnt_q;
        m_tvalid_d  = m_tvalid_q;
        frame_err_d = 1'b0;

        if (accept) begin
            in_cnt_d    = in_cnt_q + CW'(1);
            frame_err_d = io.s_tlast ^ last_in;
        end
        if (advance && adv_cnt_q != LAT_W) begin
            adv_cnt_d = adv_cnt_q + AW'(1);
        end
        if (advance && adv_cnt_q == LAT_W) begin
            m_tvalid_d = 1'b1;
        end else if (hshk) begin
            m_tvalid_d = 1'b0;
        end
        if (hshk) begin
            out_cnt_d = out_cnt_q + CW'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (end_in)      state_d = FLUSH;
                else if (accept) state_d = FILL;
            end
            FILL: begin
                if (end_in)                  state_d = FLUSH;
                else if (adv_cnt_q == LAT_W) state_d = RUN;
            end
            RUN: begin
                if (end_in) state_d = FLUSH;
            end
            FLUSH: begin
                if (hshk && last_out) begin
                    state_d   = IDLE;
                    in_cnt_d  = '0;
                    out_cnt_d = '0;
                    adv_cnt_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= IDLE;
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            adv_cnt_q   <= '0;
            m_tvalid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_cnt_q    <= in_cnt_d;
            out_cnt_q   <= out_cnt_d;
            adv_cnt_q   <= adv_cnt_d;
            m_tvalid_q  <= m_tvalid_d;
            frame_err_q <= frame_err_d;
        end
    end
endmodule

// File: tb/tb_conv_stream_ctrl.sv
// Directed bench for conv_stream_ctrl.
// A behavioural core model outputs the bitwise inverse of each beat, delayed by 18 advances.
module tb_conv_stream_ctrl;
    localparam int DW  = 64;
    localparam int BPF = 512;
    localparam int LAT = 18;

    logic clk = 1'b0;
    logic aresetn = 1'b1;
    logic busy;
    logic frame_err;
    int   n_chk = 0;
    int   n_pass = 0;

    conv_stream_if #(.DATA_WIDTH(DW)) ifc ();

    conv_stream_ctrl dut (
        .clk       (clk),
        .aresetn   (aresetn),
        .io        (ifc),
        .busy      (busy),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] sr [LAT];
    always @(posedge clk) begin
        if (ifc.conv_stall === 1'b0) begin
            for (int i = LAT - 1; i > 0; i--) sr[i] <= sr[i-1];
            sr[0] <= ifc.conv_in;
            ifc.conv_out <= ~sr[LAT-1];
        end
    end

    function automatic logic [DW-1:0] pix(input int n, input int s);
        logic [31:0] a;
        a = 32'(n * 40503 + s);
        return {a, 32'(n) ^ 32'h5A5A_0000};
    endfunction

    int r_out, r_last, r_lastpos, r_last_bad, r_err, r_data_bad, r_hold_bad;
    int r_gap_bad, r_zero, r_zero_bad, r_first_adv, r_first_acc, r_adv;
    bit r_timeout;

    task automatic run_frame(input int nin, input bit tl, input int vpct,
                             input int rpct, input int abort_at, input int seed);
        int in_idx = 0;
        int out_idx = 0;
        int adv = 0;
        int cyc = 0;
        bit hold_v = 0;
        logic [DW-1:0] hold_d = '0;
        logic [DW-1:0] exp_d;
        r_last = 0; r_lastpos = -1; r_last_bad = 0; r_err = 0;
        r_data_bad = 0; r_hold_bad = 0; r_gap_bad = 0; r_zero = 0;
        r_zero_bad = 0; r_first_adv = -1; r_first_acc = -1; r_timeout = 0;
        while (out_idx < BPF && (abort_at < 0 || out_idx < abort_at)) begin
            @(negedge clk);
            if (in_idx < nin && $urandom_range(0, 99) < vpct) begin
                ifc.s_tvalid = 1'b1;
                ifc.s_tdata  = pix(in_idx, seed);
                ifc.s_tlast  = tl && (in_idx == nin - 1);
            end else begin
                ifc.s_tvalid = 1'b0;
                ifc.s_tdata  = '0;
                ifc.s_tlast  = 1'b0;
            end
            ifc.m_tready = ($urandom_range(0, 99) < rpct);
            #1;
            if (ifc.m_tvalid === 1'b1 && r_first_adv < 0) r_first_adv = adv;
            if (hold_v && (ifc.m_tvalid !== 1'b1 || ifc.m_tdata !== hold_d))
                r_hold_bad++;
            if (in_idx < nin && !ifc.s_tvalid && ifc.conv_stall !== 1'b1)
                r_gap_bad++;
            if (ifc.conv_stall === 1'b0) begin
                adv++;
                if (in_idx >= nin) begin
                    r_zero++;
                    if (ifc.conv_in !== '0) r_zero_bad++;
                end
            end
            if (ifc.s_tvalid && ifc.s_tready === 1'b1) begin
                if (r_first_acc < 0) r_first_acc = cyc;
                in_idx++;
            end
            if (frame_err === 1'b1) r_err++;
            if (ifc.m_tvalid !== 1'b1 && ifc.m_tlast !== 1'b0) r_last_bad++;
            hold_v = (ifc.m_tvalid === 1'b1) && !ifc.m_tready;
            hold_d = ifc.m_tdata;
            if (ifc.m_tvalid === 1'b1 && ifc.m_tready) begin
                exp_d = (out_idx < nin) ? ~pix(out_idx, seed) : '1;
                if (ifc.m_tdata !== exp_d) r_data_bad++;
                if (ifc.m_tlast === 1'b1) begin
                    r_last++;
                    r_lastpos = out_idx;
                end else if (ifc.m_tlast !== 1'b0) r_last_bad++;
                out_idx++;
            end
            cyc++;
            if (cyc > 8000) begin
                r_timeout = 1;
                break;
            end
        end
        r_out = out_idx;
        r_adv = adv;
    endtask

    task automatic test_reset();
        ifc.s_tvalid = 1'b1; ifc.s_tdata = pix(0, 1); ifc.s_tlast = 1'b0;
        ifc.m_tready = 1'b1;
        #2 aresetn = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_chk++;
        if (ifc.m_tvalid !== 1'b0) $display("FAIL rst_m_tvalid got %b want 0", ifc.m_tvalid);
        else n_pass++;
        n_chk++;
        if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy);
        else n_pass++;
        n_chk++;
        if (ifc.conv_stall !== 1'b1) $display("FAIL rst_stall got %b want 1", ifc.conv_stall);
        else n_pass++;
        n_chk++;
        if (frame_err !== 1'b0) $display("FAIL rst_frame_err got %b want 0", frame_err);
        else n_pass++;
        @(negedge clk);
        aresetn = 1'b1;
        #1;
        n_chk++;
        if (ifc.s_tready !== 1'b1 || ifc.conv_stall !== 1'b0)
            $display("FAIL rel_accept got rdy=%b stall=%b want 1/0", ifc.s_tready, ifc.conv_stall);
        else n_pass++;
        ifc.s_tvalid = 1'b0;
        @(negedge clk);
        #1;
        n_chk++;
        if (busy !== 1'b0) $display("FAIL rel_idle got %b want 0", busy);
        else n_pass++;
    endtask

    task automatic test_full_frame();
        run_frame(BPF, 1, 100, 100, -1, 7);
        n_chk++;
        if (r_timeout !== 0 || r_out !== BPF) $display("FAIL full_count got %0d want %0d", r_out, BPF);
        else n_pass++;
        n_chk++;
        if (r_first_adv !== LAT + 1) $display("FAIL full_first got %0d want %0d", r_first_adv, LAT + 1);
        else n_pass++;
        n_chk++;
        if (r_last !== 1 || r_lastpos !== BPF - 1 || r_last_bad !== 0)
            $display("FAIL full_tlast got n=%0d pos=%0d bad=%0d want 1/511/0", r_last, r_lastpos, r_last_bad);
        else n_pass++;
        n_chk++;
        if (r_zero !== LAT || r_zero_bad !== 0 || r_adv !== BPF + LAT)
            $display("FAIL full_flush got z=%0d bad=%0d adv=%0d want 18/0/530", r_zero, r_zero_bad, r_adv);
        else n_pass++;
        n_chk++;
        if (r_data_bad !== 0) $display("FAIL full_data got %0d bad want 0", r_data_bad);
        else n_pass++;
        n_chk++;
        if (r_err !== 0) $display("FAIL full_err got %0d want 0", r_err);
        else n_pass++;
        @(negedge clk);
        ifc.s_tvalid = 1'b0;
        #1;
        n_chk++;
        if (busy !== 1'b0) $display("FAIL full_idle got %b want 0", busy);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        run_frame(BPF, 1, 100, 50, -1, 33);
        n_chk++;
        if (r_timeout !== 0 || r_out !== BPF) $display("FAIL bp_count got %0d want %0d", r_out, BPF);
        else n_pass++;
        n_chk++;
        if (r_hold_bad !== 0) $display("FAIL bp_hold got %0d want 0", r_hold_bad);
        else n_pass++;
        n_chk++;
        if (r_data_bad !== 0) $display("FAIL bp_data got %0d bad want 0", r_data_bad);
        else n_pass++;
        n_chk++;
        if (r_last !== 1 || r_lastpos !== BPF - 1 || r_last_bad !== 0)
            $display("FAIL bp_tlast got n=%0d pos=%0d want 1/511", r_last, r_lastpos);
        else n_pass++;
    endtask

    task automatic test_input_gaps();
        run_frame(BPF, 1, 50, 100, -1, 7);
        n_chk++;
        if (r_timeout !== 0 || r_out !== BPF) $display("FAIL gap_count got %0d want %0d", r_out, BPF);
        else n_pass++;
        n_chk++;
        if (r_gap_bad !== 0) $display("FAIL gap_stall got %0d want 0", r_gap_bad);
        else n_pass++;
        n_chk++;
        if (r_first_adv !== LAT + 1 || r_zero !== LAT)
            $display("FAIL gap_fill got first=%0d z=%0d want 19/18", r_first_adv, r_zero);
        else n_pass++;
        n_chk++;
        if (r_data_bad !== 0) $display("FAIL gap_data got %0d bad want 0", r_data_bad);
        else n_pass++;
    endtask

    task automatic test_early_tlast();
        run_frame(101, 1, 100, 100, -1, 91);
        n_chk++;
        if (r_err !== 1) $display("FAIL early_err got %0d want 1", r_err);
        else n_pass++;
        n_chk++;
        if (r_timeout !== 0 || r_out !== BPF) $display("FAIL early_count got %0d want %0d", r_out, BPF);
        else n_pass++;
        n_chk++;
        if (r_zero !== BPF + LAT - 101 || r_zero_bad !== 0)
            $display("FAIL early_zero got %0d bad=%0d want 429/0", r_zero, r_zero_bad);
        else n_pass++;
        n_chk++;
        if (r_data_bad !== 0) $display("FAIL early_data got %0d bad want 0", r_data_bad);
        else n_pass++;
        n_chk++;
        if (r_last !== 1 || r_lastpos !== BPF - 1)
            $display("FAIL early_tlast got n=%0d pos=%0d want 1/511", r_last, r_lastpos);
        else n_pass++;
    endtask

    task automatic test_missing_tlast();
        run_frame(BPF, 0, 100, 100, -1, 55);
        n_chk++;
        if (r_err !== 1) $display("FAIL miss_err got %0d want 1", r_err);
        else n_pass++;
        n_chk++;
        if (r_timeout !== 0 || r_out !== BPF || r_data_bad !== 0)
            $display("FAIL miss_frame got n=%0d bad=%0d want 512/0", r_out, r_data_bad);
        else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        run_frame(BPF, 1, 100, 100, 200, 12);
        n_chk++;
        if (r_out !== 200) $display("FAIL mid_reach got %0d want 200", r_out);
        else n_pass++;
        @(negedge clk);
        ifc.s_tvalid = 1'b0;
        aresetn = 1'b0;
        #1;
        n_chk++;
        if (busy !== 1'b0 || ifc.m_tvalid !== 1'b0)
            $display("FAIL mid_drop got busy=%b v=%b want 0/0", busy, ifc.m_tvalid);
        else n_pass++;
        repeat (2) @(negedge clk);
        aresetn = 1'b1;
        run_frame(BPF, 1, 100, 100, -1, 77);
        n_chk++;
        if (r_first_adv !== LAT + 1) $display("FAIL mid_first got %0d want %0d", r_first_adv, LAT + 1);
        else n_pass++;
        n_chk++;
        if (r_timeout !== 0 || r_out !== BPF || r_data_bad !== 0 || r_last !== 1)
            $display("FAIL mid_frame got n=%0d bad=%0d last=%0d want 512/0/1", r_out, r_data_bad, r_last);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        run_frame(BPF, 1, 100, 100, -1, 3);
        run_frame(BPF, 1, 100, 100, -1, 4);
        n_chk++;
        if (r_first_acc !== 0) $display("FAIL b2b_accept got %0d want 0", r_first_acc);
        else n_pass++;
        n_chk++;
        if (r_first_adv !== LAT + 1) $display("FAIL b2b_first got %0d want %0d", r_first_adv, LAT + 1);
        else n_pass++;
        n_chk++;
        if (r_timeout !== 0 || r_out !== BPF || r_data_bad !== 0)
            $display("FAIL b2b_frame got n=%0d bad=%0d want 512/0", r_out, r_data_bad);
        else n_pass++;
    endtask

    initial begin
        ifc.s_tvalid = 1'b0;
        ifc.s_tdata  = '0;
        ifc.s_tlast  = 1'b0;
        ifc.m_tready = 1'b0;
        test_reset();
        test_full_frame();
        test_backpressure();
        test_input_gaps();
        test_early_tlast();
        test_missing_tlast();
        test_reset_mid_frame();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
